// File: rtl/level_channel_arbiter_pkg.sv
// Shared level-meter definitions: default sample width and a clog2 helper
// that never returns less than one bit.
package level_channel_arbiter_pkg;

   localparam int DEFAULT_WIDTH = 16;

   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 30; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/level_channel_arbiter_if.sv
// Handshake bundle between level sources, the arbiter and the downstream
// record consumer; slave is the arbiter side, master the environment side.
interface level_channel_arbiter_if
   import level_channel_arbiter_pkg::*;
#(
   parameter int width    = DEFAULT_WIDTH,
   parameter int channels = 2
);

   localparam int CW = clog2_min1(channels);

   logic [channels-1:0]       i_valid;
   logic [channels-1:0]       i_ready;
   logic [channels*width-1:0] i_value;
   logic                      o_valid;
   logic                      o_ready;
   logic [width-1:0]          o_value;
   logic [width-1:0]          o_peak;
   logic [CW-1:0]             o_channel;

   modport slave (
      input  i_valid, i_value, o_ready,
      output i_ready, o_valid, o_value, o_peak, o_channel
   );

   modport master (
      output i_valid, i_value, o_ready,
      input  i_ready, o_valid, o_value, o_peak, o_channel
   );

endinterface

// File: rtl/round_robin_grant.sv
// Cyclic priority pick: one-hot grant to the first requester at or after ptr,
// wrapping past the top channel. Purely combinational.
module round_robin_grant #(
   parameter int channels = 2,
   parameter int ptr_w    = 1
) (
   input  logic [channels-1:0] req_i,
   input  logic [ptr_w-1:0]    ptr_i,
   output logic [channels-1:0] grant_o
);

   logic hi_hit;
   logic any_hit;

   // First pass covers ptr..top, second pass wraps around to 0..ptr-1.
   always_comb begin
      grant_o = '0;
      hi_hit  = 1'b0;
      any_hit = 1'b0;
      for (int i = 0; i < channels; i++) begin
         if (!hi_hit && req_i[i] && (i >= int'(ptr_i))) begin
            grant_o[i] = 1'b1;
            hi_hit     = 1'b1;
         end
      end
      any_hit = hi_hit;
      for (int i = 0; i < channels; i++) begin
         if (!any_hit && req_i[i]) begin
            grant_o[i] = 1'b1;
            any_hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/level_channel_arbiter.sv
// Round-robin merge of per-channel level samples into one record stream with a
// per-channel peak-hold window; 1-cycle latency, full throughput, holds while o_ready low.
module level_channel_arbiter
   import level_channel_arbiter_pkg::*;
#(
   parameter int width        = DEFAULT_WIDTH,
   parameter int channels     = 2,
   parameter int hold_samples = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   level_channel_arbiter_if.slave bus
);

   localparam int CW = clog2_min1(channels);
   localparam int NW = clog2_min1(hold_samples);

   logic [channels-1:0]       grant;
   logic [CW-1:0]             ptr_q, ptr_d;
   logic [CW-1:0]             grant_idx;
   logic                      out_free;
   logic                      take;
   logic [width-1:0]          sample;
   logic [width-1:0]          peak_sel;
   logic [channels*width-1:0] peak_upd;

   logic             o_valid_q, o_valid_d;
   logic [width-1:0] o_value_q, o_value_d;
   logic [width-1:0] o_peak_q, o_peak_d;
   logic [CW-1:0]    o_channel_q, o_channel_d;

   round_robin_grant #(
      .channels (channels),
      .ptr_w    (CW)
   ) u_rr (
      .req_i   (bus.i_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant)
   );

   // The output register can take a new record whenever the old one leaves this cycle.
   assign out_free    = !o_valid_q || bus.o_ready;
   assign bus.i_ready = (reset || !out_free) ? '0 : grant;
   assign take        = out_free && (|grant) && !reset;

   always_comb begin
      grant_idx = '0;
      sample    = '0;
      peak_sel  = '0;
      for (int k = 0; k < channels; k++) begin
         if (grant[k]) begin
            grant_idx = CW'(k);
            sample    = bus.i_value[k*width +: width];
            peak_sel  = peak_upd[k*width +: width];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (take) begin
         ptr_d = (grant_idx == CW'(channels - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_comb begin
      o_valid_d   = o_valid_q;
      o_value_d   = o_value_q;
      o_peak_d    = o_peak_q;
      o_channel_d = o_channel_q;
      if (take) begin
         o_valid_d   = 1'b1;
         o_value_d   = sample;
         o_peak_d    = peak_sel;
         o_channel_d = grant_idx;
      end else if (bus.o_ready) begin
         o_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         o_valid_q   <= 1'b0;
         o_value_q   <= '0;
         o_peak_q    <= '0;
         o_channel_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         o_valid_q   <= o_valid_d;
         o_value_q   <= o_value_d;
         o_peak_q    <= o_peak_d;
         o_channel_q <= o_channel_d;
      end
   end

   for (genvar k = 0; k < channels; k++) begin : g_ch
      logic [width-1:0] peak_q, peak_d;
      logic [width-1:0] smp;
      logic [NW-1:0]    cnt_q, cnt_d;
      logic             hit;

      assign smp = bus.i_value[k*width +: width];
      assign hit = take && grant[k];

      // A zero count opens a fresh window, so the old peak is discarded.
      always_comb begin
         peak_d = peak_q;
         cnt_d  = cnt_q;
         if (hit) begin
            if ((cnt_q == '0) || (smp > peak_q)) peak_d = smp;
            cnt_d = (cnt_q == NW'(hold_samples - 1)) ? '0 : cnt_q + 1'b1;
         end
      end

      assign peak_upd[k*width +: width] = peak_d;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            peak_q <= '0;
            cnt_q  <= '0;
         end else begin
            peak_q <= peak_d;
            cnt_q  <= cnt_d;
         end
      end
   end

   assign bus.o_valid   = o_valid_q;
   assign bus.o_value   = o_value_q;
   assign bus.o_peak    = o_peak_q;
   assign bus.o_channel = o_channel_q;

endmodule

// File: tb/tb_level_channel_arbiter.sv
// Scoreboarded bench: per-channel source queues feed two arbiter instances
// (2 and 3 channels); monitors pop expected records on each output transfer.
module tb_level_channel_arbiter;

   typedef struct packed {
      logic [2:0]  ch;
      logic [15:0] val;
      logic [15:0] peak;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   level_channel_arbiter_if #(.width(16), .channels(2)) ifa ();
   level_channel_arbiter_if #(.width(16), .channels(3)) ifb ();

   level_channel_arbiter #(.width(16), .channels(2), .hold_samples(4)) dut_a (
      .clk   (clk),
      .reset (rst),
      .bus   (ifa.slave)
   );

   level_channel_arbiter #(.width(16), .channels(3), .hold_samples(4)) dut_b (
      .clk   (clk),
      .reset (rst),
      .bus   (ifb.slave)
   );

   logic [15:0] sa0[$], sa1[$], sb0[$], sb1[$], sb2[$];
   rec_t        exp_a[$], exp_b[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic rec_t mk(input int ch, input logic [15:0] v, input logic [15:0] p);
      rec_t r;
      r.ch   = 3'(ch);
      r.val  = v;
      r.peak = p;
      return r;
   endfunction

   task automatic ea(input int ch, input logic [15:0] v, input logic [15:0] p);
      exp_a.push_back(mk(ch, v, p));
   endtask

   task automatic eb(input int ch, input logic [15:0] v, input logic [15:0] p);
      exp_b.push_back(mk(ch, v, p));
   endtask

   task automatic drain_a(input int budget, input string name, output int n);
      n = 0;
      while (exp_a.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(exp_a.size()), 64'd0);
   endtask

   task automatic drain_b(input int budget, input string name, output int n);
      n = 0;
      while (exp_b.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(exp_b.size()), 64'd0);
   endtask

   task automatic wait_valid_a(input string name);
      int k;
      k = 0;
      while (!ifa.o_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(ifa.o_valid), 64'd1);
   endtask

   // Sources: present queue heads; pop a head only after it was accepted.
   initial begin
      logic [1:0] acc;
      ifa.i_valid = '0;
      ifa.i_value = '0;
      forever begin
         @(negedge clk);
         acc = ifa.i_valid & ifa.i_ready;
         @(posedge clk);
         #1;
         if (acc[0]) void'(sa0.pop_front());
         if (acc[1]) void'(sa1.pop_front());
         ifa.i_valid = {sa1.size() != 0, sa0.size() != 0};
         ifa.i_value = {(sa1.size() != 0) ? sa1[0] : 16'h0, (sa0.size() != 0) ? sa0[0] : 16'h0};
      end
   end

   initial begin
      logic [2:0] acc;
      ifb.i_valid = '0;
      ifb.i_value = '0;
      forever begin
         @(negedge clk);
         acc = ifb.i_valid & ifb.i_ready;
         @(posedge clk);
         #1;
         if (acc[0]) void'(sb0.pop_front());
         if (acc[1]) void'(sb1.pop_front());
         if (acc[2]) void'(sb2.pop_front());
         ifb.i_valid = {sb2.size() != 0, sb1.size() != 0, sb0.size() != 0};
         ifb.i_value = {(sb2.size() != 0) ? sb2[0] : 16'h0,
                        (sb1.size() != 0) ? sb1[0] : 16'h0,
                        (sb0.size() != 0) ? sb0[0] : 16'h0};
      end
   end

   always @(negedge clk) begin
      if (!rst && ifa.o_valid && ifa.o_ready) begin
         if (exp_a.size() == 0) begin
            n_chk++;
            $display("FAIL a_unexpected_record: got ch %0d val %h peak %h, expected none",
                     ifa.o_channel, ifa.o_value, ifa.o_peak);
         end else begin
            rec_t e;
            e = exp_a.pop_front();
            chk("a_record", {29'd0, 2'd0, ifa.o_channel, ifa.o_value, ifa.o_peak}, 64'(e));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ifb.o_valid && ifb.o_ready) begin
         if (exp_b.size() == 0) begin
            n_chk++;
            $display("FAIL b_unexpected_record: got ch %0d val %h peak %h, expected none",
                     ifb.o_channel, ifb.o_value, ifb.o_peak);
         end else begin
            rec_t e;
            e = exp_b.pop_front();
            chk("b_record", {29'd0, 1'd0, ifb.o_channel, ifb.o_value, ifb.o_peak}, 64'(e));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      ifa.o_ready = 1'b1;
      ifb.o_ready = 1'b1;
      #1 rst = 1'b1;

      // Ch0 alone: peak-hold window of four, then a fresh window.
      sa0.push_back(16'h1111); ea(0, 16'h1111, 16'h1111);
      sa0.push_back(16'h4444); ea(0, 16'h4444, 16'h4444);
      sa0.push_back(16'h2222); ea(0, 16'h2222, 16'h4444);
      sa0.push_back(16'h3333); ea(0, 16'h3333, 16'h4444);
      sa0.push_back(16'h0500); ea(0, 16'h0500, 16'h0500);
      @(negedge clk);
      @(negedge clk);
      chk("a_rst_o_valid", 64'(ifa.o_valid), 64'd0);
      chk("a_rst_o_value", 64'(ifa.o_value), 64'd0);
      chk("a_rst_o_peak", 64'(ifa.o_peak), 64'd0);
      chk("a_rst_o_channel", 64'(ifa.o_channel), 64'd0);
      chk("a_rst_i_ready", 64'(ifa.i_ready), 64'd0);
      chk("b_rst_o_valid", 64'(ifb.o_valid), 64'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      drain_a(30, "a_ch0_window_drain", n);

      // Unsigned max across the window: FFFF must not be displaced by 0000.
      sa0.push_back(16'hFFFF); ea(0, 16'hFFFF, 16'hFFFF);
      sa0.push_back(16'h0000); ea(0, 16'h0000, 16'hFFFF);
      sa0.push_back(16'h0001); ea(0, 16'h0001, 16'hFFFF);
      sa0.push_back(16'h0002); ea(0, 16'h0002, 16'h0002);
      drain_a(30, "a_unsigned_max_drain", n);

      // Both streaming, ptr=1 after ch0: ch1 first, then strict alternation.
      sa0.push_back(16'h0010); sa0.push_back(16'h0030); sa0.push_back(16'h0020); sa0.push_back(16'h0040);
      sa1.push_back(16'h0100); sa1.push_back(16'h0300); sa1.push_back(16'h0200); sa1.push_back(16'h0050);
      ea(1, 16'h0100, 16'h0100); ea(0, 16'h0010, 16'h0010);
      ea(1, 16'h0300, 16'h0300); ea(0, 16'h0030, 16'h0030);
      ea(1, 16'h0200, 16'h0300); ea(0, 16'h0020, 16'h0030);
      ea(1, 16'h0050, 16'h0300); ea(0, 16'h0040, 16'h0040);
      drain_a(40, "a_alternate_drain", n);
      chk("a_alternate_throughput", 64'(n <= 10), 64'd1);

      // Backpressure: first record held five cycles, no further accepts.
      @(posedge clk);
      #1 ifa.o_ready = 1'b0;
      @(negedge clk);
      sa1.push_back(16'h0B00); sa1.push_back(16'h0C00); sa0.push_back(16'h0A00);
      ea(1, 16'h0B00, 16'h0B00); ea(0, 16'h0A00, 16'h0A00); ea(1, 16'h0C00, 16'h0C00);
      wait_valid_a("a_hold_first_accept");
      for (int c = 0; c < 5; c++) begin
         chk("a_hold_record", {29'd0, 2'd0, ifa.o_channel, ifa.o_value, ifa.o_peak},
             {29'd0, 3'd1, 16'h0B00, 16'h0B00});
         chk("a_hold_i_ready", 64'(ifa.i_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 ifa.o_ready = 1'b1;
      drain_a(30, "a_hold_release_drain", n);

      // Reset with a held ch0 record and ch1 mid-window (cnt=2).
      @(posedge clk);
      #1 ifa.o_ready = 1'b0;
      @(negedge clk);
      sa0.push_back(16'h0E00);
      sa1.push_back(16'h0100);
      wait_valid_a("a_pre_reset_valid");
      chk("a_pre_reset_record", {29'd0, 2'd0, ifa.o_channel, ifa.o_value, ifa.o_peak},
          {29'd0, 3'd0, 16'h0E00, 16'h0E00});
      #2 rst = 1'b1;
      #1;
      chk("a_async_rst_o_valid", 64'(ifa.o_valid), 64'd0);
      chk("a_async_rst_o_value", 64'(ifa.o_value), 64'd0);
      chk("a_async_rst_o_peak", 64'(ifa.o_peak), 64'd0);
      chk("a_async_rst_i_ready", 64'(ifa.i_ready), 64'd0);
      ea(1, 16'h0100, 16'h0100);
      @(posedge clk);
      #1 ifa.o_ready = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("a_first_edge_after_reset", 64'(ifa.o_valid), 64'd1);
      sa0.push_back(16'h0001); ea(0, 16'h0001, 16'h0001);
      drain_a(30, "a_post_reset_drain", n);

      // Three channels: ch2 alone wraps ptr to 0, so ch0 beats ch2 next.
      sb2.push_back(16'h0002); eb(2, 16'h0002, 16'h0002);
      drain_b(30, "b_ch2_only_drain", n);
      sb0.push_back(16'h0010); sb2.push_back(16'h0001);
      eb(0, 16'h0010, 16'h0010); eb(2, 16'h0001, 16'h0002);
      drain_b(30, "b_wrap_drain", n);
      sb0.push_back(16'h0200); sb1.push_back(16'h0100);
      eb(0, 16'h0200, 16'h0200); eb(1, 16'h0100, 16'h0100);
      drain_b(30, "b_ch0_ch1_drain", n);

      repeat (3) @(negedge clk);
      chk("a_scoreboard_empty", 64'(exp_a.size()), 64'd0);
      chk("b_scoreboard_empty", 64'(exp_b.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
